// File: rtl/ram_block_engine.sv
// Block copy/fill engine driving the secondary port of ram_unit.
// Next-cycle outputs are computed from the next state and registered, so no input reaches the memory pins combinationally.
module ram_block_engine #(
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [A-1:0] src,
    input  logic [A-1:0] dst,
    input  logic [A:0]   len,
    input  logic [D-1:0] fill_value,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] mem_address,
    output logic [D-1:0] mem_wdata,
    input  logic [D-1:0] mem_rdata,
    output logic         mem_ce,
    output logic         mem_we
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_r, nxt_state_s;
    logic [A:0]   idx_r, nxt_idx_s;
    logic [A-1:0] src_r, nxt_src_s;
    logic [A-1:0] dst_r, nxt_dst_s;
    logic [A:0]   len_r, nxt_len_s;
    logic [D-1:0] fill_r, nxt_fill_s;
    logic [D-1:0] hold_r, nxt_hold_s;
    logic         last_s;

    logic         nxt_busy_s, nxt_done_s, nxt_ce_s, nxt_we_s;
    logic [A-1:0] nxt_addr_s;
    logic [D-1:0] nxt_wdata_s;

    assign last_s = ((idx_r + {{A{1'b0}}, 1'b1}) == len_r);

    // Next-state and command-register update
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_src_s   = src_r;
        nxt_dst_s   = dst_r;
        nxt_len_s   = len_r;
        nxt_fill_s  = fill_r;
        nxt_hold_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nxt_src_s  = src;
                    nxt_dst_s  = dst;
                    nxt_len_s  = len;
                    nxt_fill_s = fill_value;
                    nxt_idx_s  = {(A+1){1'b0}};
                    if (len == {(A+1){1'b0}}) begin
                        nxt_state_s = DONE;
                    end else if (mode) begin
                        nxt_state_s = FILL;
                    end else begin
                        nxt_state_s = READ;
                    end
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            READ: begin
                nxt_hold_s  = mem_rdata;
                nxt_state_s = WRITE;
            end
            WRITE: begin
                nxt_idx_s = idx_r + {{A{1'b0}}, 1'b1};
                if (last_s) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_state_s = READ;
                end
            end
            FILL: begin
                nxt_idx_s = idx_r + {{A{1'b0}}, 1'b1};
                if (last_s) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_state_s = FILL;
                end
            end
            DONE: begin
                nxt_state_s = IDLE;
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Decode of the upcoming state into the memory-port values it must present
    always_comb begin
        nxt_busy_s  = 1'b0;
        nxt_done_s  = 1'b0;
        nxt_ce_s    = 1'b0;
        nxt_we_s    = 1'b0;
        nxt_addr_s  = {A{1'b0}};
        nxt_wdata_s = {D{1'b0}};
        case (nxt_state_s)
            READ: begin
                nxt_busy_s = 1'b1;
                nxt_ce_s   = 1'b1;
                nxt_addr_s = nxt_src_s + nxt_idx_s[A-1:0];
            end
            WRITE: begin
                nxt_busy_s  = 1'b1;
                nxt_ce_s    = 1'b1;
                nxt_we_s    = 1'b1;
                nxt_addr_s  = nxt_dst_s + nxt_idx_s[A-1:0];
                nxt_wdata_s = nxt_hold_s;
            end
            FILL: begin
                nxt_busy_s  = 1'b1;
                nxt_ce_s    = 1'b1;
                nxt_we_s    = 1'b1;
                nxt_addr_s  = nxt_dst_s + nxt_idx_s[A-1:0];
                nxt_wdata_s = nxt_fill_s;
            end
            DONE: begin
                nxt_done_s = 1'b1;
            end
            default: begin
                nxt_busy_s = 1'b0;
            end
        endcase
    end

    // State, command and hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {(A+1){1'b0}};
            src_r   <= {A{1'b0}};
            dst_r   <= {A{1'b0}};
            len_r   <= {(A+1){1'b0}};
            fill_r  <= {D{1'b0}};
            hold_r  <= {D{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            idx_r   <= nxt_idx_s;
            src_r   <= nxt_src_s;
            dst_r   <= nxt_dst_s;
            len_r   <= nxt_len_s;
            fill_r  <= nxt_fill_s;
            hold_r  <= nxt_hold_s;
        end
    end

    // Registered outputs; reset clears them without a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= {A{1'b0}};
            mem_wdata   <= {D{1'b0}};
        end else begin
            busy        <= nxt_busy_s;
            done        <= nxt_done_s;
            mem_ce      <= nxt_ce_s;
            mem_we      <= nxt_we_s;
            mem_address <= nxt_addr_s;
            mem_wdata   <= nxt_wdata_s;
        end
    end

endmodule

// File: tb/tb_ram_block_engine.sv
// Directed bench for ram_block_engine with a behavioural RAM, a shadow memory model
// and a queue of expected writes that is popped as the engine writes.
module tb_ram_block_engine;
    localparam int A = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [A-1:0] src, dst;
    logic [A:0]   len;
    logic [D-1:0] fill_value;
    logic         busy, done;
    logic [A-1:0] mem_address;
    logic [D-1:0] mem_wdata, mem_rdata;
    logic         mem_ce, mem_we;

    logic [7:0] mem [0:255];
    logic [7:0] shadow [0:255];
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int failures = 0;

    ram_block_engine #(.A(A), .D(D)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_value(fill_value), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we)
    );

    always #5 if (clk_en) clk = ~clk;

    // Behavioural RAM: asynchronous read, synchronous write, plus a bench preload path
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_ce && mem_we) mem[mem_address] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = v;
        shadow[a] = v;
    endtask

    task automatic do_cmd(input string tag, input logic m, input logic [7:0] s,
                          input logic [7:0] d, input logic [8:0] n,
                          input logic [7:0] f, input int glitch_k);
        int busy_cnt, ce_cnt, done_k, exp_busy, exp_done;
        logic [7:0] v, a;
        wr_t w;
        for (int i = 0; i < int'(n); i++) begin
            v = m ? f : shadow[8'(s + i)];
            shadow[8'(d + i)] = v;
            w.a = 8'(d + i);
            w.d = v;
            exp_q.push_back(w);
        end
        exp_busy = m ? int'(n) : 2 * int'(n);
        exp_done = exp_busy + 1;
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = n; fill_value = f;
        @(negedge clk);
        mode = ~m; src = 8'($urandom); dst = 8'($urandom);
        len = 9'($urandom); fill_value = 8'($urandom);
        busy_cnt = 0; ce_cnt = 0; done_k = 0;
        for (int k = 1; k <= 600; k++) begin
            start = (k == glitch_k) ? 1'b1 : 1'b0;
            if (busy) begin
                busy_cnt++;
                chk({tag, " we_pattern"}, {31'd0, mem_we}, m ? 32'd1 : ((k % 2 == 0) ? 32'd1 : 32'd0));
            end
            if (mem_ce) ce_cnt++;
            if (mem_ce && mem_we) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " extra_write"}, 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk({tag, " wr_addr"}, {24'd0, mem_address}, {24'd0, w.a});
                    chk({tag, " wr_data"}, {24'd0, mem_wdata}, {24'd0, w.d});
                end
            end
            if (done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done_cycle"}, done_k, exp_done);
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, " ce_cycles"}, ce_cnt, exp_busy);
        chk({tag, " writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        for (int j = -1; j <= int'(n); j++) begin
            a = 8'(int'(d) + j);
            chk({tag, " mem"}, {24'd0, mem[a]}, {24'd0, shadow[a]});
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_value = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2 rst = 1'b1;
        #2;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst ce", {31'd0, mem_ce}, 32'd0);
        chk("rst we", {31'd0, mem_we}, 32'd0);
        chk("rst addr", {24'd0, mem_address}, 32'd0);
        chk("rst wdata", {24'd0, mem_wdata}, 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'(i) ^ 8'h5A);
        poke(8'h00, 8'h11);
        poke(8'h01, 8'h22);
        poke(8'h02, 8'h33);
        poke(8'h20, 8'h07);
        @(negedge clk);
        ld_en = 1'b0;

        do_cmd("fill4", 1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 0);
        do_cmd("copy3", 1'b0, 8'h00, 8'h80, 9'd3, 8'h00, 0);
        do_cmd("fill_wrap", 1'b1, 8'h00, 8'hFE, 9'd3, 8'hC3, 0);
        do_cmd("copy_overlap", 1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 0);
        do_cmd("copy_srcwrap", 1'b0, 8'hFE, 8'h60, 9'd4, 8'h00, 0);
        do_cmd("len0", 1'b1, 8'h00, 8'h30, 9'd0, 8'hEE, 0);
        do_cmd("glitch", 1'b0, 8'h00, 8'h90, 9'd3, 8'h00, 2);
        do_cmd("fill_glitch", 1'b1, 8'h00, 8'hB0, 9'd5, 8'h6D, 3);

        // Reset in the middle of a 4-word fill after two words have been written
        shadow[8'h40] = 8'h3C;
        shadow[8'h41] = 8'h3C;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst = 8'h40; len = 9'd4; fill_value = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        chk("mid we1", {31'd0, mem_we}, 32'd1);
        chk("mid addr1", {24'd0, mem_address}, 32'h40);
        @(negedge clk);
        chk("mid addr2", {24'd0, mem_address}, 32'h41);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid busy", {31'd0, busy}, 32'd0);
        chk("mid we", {31'd0, mem_we}, 32'd0);
        chk("mid ce", {31'd0, mem_ce}, 32'd0);
        chk("mid addr", {24'd0, mem_address}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 8'h3F; a <= 8'h44; a++)
            chk("mid mem", {24'd0, mem[8'(a)]}, {24'd0, shadow[8'(a)]});
        do_cmd("after_rst", 1'b1, 8'h00, 8'h40, 9'd4, 8'h99, 0);

        do_cmd("fill_all", 1'b1, 8'h00, 8'h07, 9'd256, 8'h4B, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_block_engine.md
# ram_block_engine

Single-port initiator for `ram_unit`. It drives one of the RAM's two ports to run block operations on command: a forward copy of `len` words from `src` to `dst`, or a fill of `len` words at `dst` with a constant. It sits between the control logic and the RAM's second port (`iaddress`/`idbusi`/`idbuso`/`ice`/`iwe`), so bulk moves do not take cycles from the primary port.

## Interface
- `A`, default 8: RAM address width; same value as the attached `ram_unit`.
- `D`, default 8: RAM data width; same value as the attached `ram_unit`.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src`  in  A  copy source base address; sampled with `start`.
- `dst`  in  A  destination base address; sampled with `start`.
- `len`  in  A+1  word count, 0..2^A; sampled with `start`.
- `fill_value`  in  D  fill word; sampled with `start`.
- `busy`  out  1  high while a command executes.
- `done`  out  1  one-cycle pulse when a command completes.
- `mem_address`  out  A  connects to the RAM `iaddress`.
- `mem_wdata`  out  D  connects to the RAM `idbusi`.
- `mem_rdata`  in  D  connects to the RAM `idbuso`; asynchronous read data.
- `mem_ce`  out  1  connects to the RAM `ice`.
- `mem_we`  out  1  connects to the RAM `iwe`.

## Operation
- State machine states: IDLE, READ, WRITE, FILL, DONE.
- IDLE, on `start`=1:
  - Latch `mode`, `src`, `dst`, `len` and `fill_value`; clear the word index `i`.
  - If `len`=0, go to DONE.
  - Otherwise go to READ when `mode`=0, or to FILL when `mode`=1.
- `start` is ignored in every state except IDLE. Command inputs may change freely after the `start` cycle.
- READ (copy only):
  - Drive `mem_ce`=1, `mem_we`=0, `mem_address`=`src`+`i`.
  - Capture `mem_rdata` into the hold register at the clock edge, then go to WRITE.
- WRITE (copy only):
  - Drive `mem_ce`=1, `mem_we`=1, `mem_address`=`dst`+`i`, `mem_wdata`=hold register.
  - Increment `i`. Go to DONE if `i`+1=`len`, otherwise back to READ.
- FILL:
  - Drive `mem_ce`=1, `mem_we`=1, `mem_address`=`dst`+`i`, `mem_wdata`=`fill_value`.
  - Increment `i`. Go to DONE if `i`+1=`len`, otherwise stay in FILL.
- DONE: assert `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- Address arithmetic is A bits wide and wraps modulo 2^A, e.g. `src`=0xFF, `i`=1 gives address 0x00. `i` is A+1 bits wide, so `len`=2^A covers the whole memory.
- Copy is strictly word-by-word and forward. When the regions overlap with `dst`>`src`, the source words are replicated; this is the defined behaviour, not an error.
- In IDLE and DONE: `mem_ce`=0, `mem_we`=0, `mem_address`=0, `mem_wdata`=0. The engine never asserts `mem_we` outside WRITE and FILL.
- Reset, including mid-command:
  - State returns to IDLE and the command is abandoned; words already written stay written.
  - All outputs go to 0 immediately, without waiting for a clock edge: `busy`, `done`, `mem_ce`, `mem_we`, `mem_address`, `mem_wdata`.
  - The hold register and `i` clear to 0.

## Timing
- `start` is sampled at edge 0. The first memory cycle follows edge 0, and `busy`=1 from then on.
- Copy of `len`=N:
  - 2N memory cycles: read and write alternate, one cycle each.
  - The `done` pulse occupies cycle 2N+1 after edge 0.
  - `busy` is high for exactly 2N cycles.
- Fill of `len`=N: N write cycles; the `done` pulse occupies cycle N+1; `busy` is high for exactly N cycles.
- `len`=0: `done` pulses in the cycle after `start`, with no `mem_ce` activity and `busy` never high.
- A new `start` can be accepted in the cycle after `done`, i.e. back in IDLE.
- Outputs are registered state decodes, so there is no combinational path from `start` to the memory signals.
- `mem_rdata` is used only in READ and must settle within the same cycle, which the asynchronous RAM read path provides.

## Test plan
- Reset: assert `rst` with no clock running → all outputs read 0.
- Fill: `mode`=1, `dst`=0x10, `len`=4, `fill_value`=0xA5 → RAM[0x10..0x13]=0xA5; `busy` high for 4 cycles; `done` one cycle later; RAM[0x0F] and RAM[0x14] unchanged.
- Copy: RAM[0x00..0x02]=11,22,33, `src`=0x00, `dst`=0x80, `len`=3 → RAM[0x80..0x82]=11,22,33; `busy` high for 6 cycles; `we` pattern 0,1,0,1,0,1.
- Wrap and overlap:
  - Fill `dst`=0xFE, `len`=3 → writes land at 0xFE, 0xFF, 0x00.
  - Copy `src`=0x20, `dst`=0x21, `len`=3 with RAM[0x20]=7 → RAM[0x21..0x23]=7.
- Edge commands:
  - `len`=0 → `done` one cycle after `start`, no write.
  - `start` pulsed while busy → ignored; the original command completes unchanged.
- Mid-command reset: assert `rst` after 2 writes of a 4-word fill → `busy`=0 and `mem_we`=0 at once; exactly 2 words are written; the next `start` after release runs normally.
